// File: rtl/decode_stage.sv
// decode_stage: MIPS ID stage - instruction decode, 32x32 register file, beq resolve, ID/EX register.
// Latency: PCsrcD/pcBranchD/RsD/RtD/BranchD are combinational; all *E outputs register 1 cycle after decode.
// Backpressure: none here; stall is applied at IF/ID, and flushE loads a bubble into ID/EX.
//
// Ports:
//   CLK, reset                 - clock (rising edge) and async active-high reset
//   instructionD, pcplus4D     - from IF/ID
//   flushE                     - load an all-zero bubble into ID/EX
//   ForwardAD/BD, ALUOutM      - branch comparator forwarding from memory stage
//   RegWriteW/WriteRegW/ResultW- register file write port (writeback)
//   PCsrcD, pcBranchD          - taken flag and target back to fetch
//   RsD, RtD, BranchD          - to hazard unit
//   *E                         - ID/EX pipeline register contents for execute
// Optional feature: define JUMP_EN to decode j (opcode 000010).
module decode_stage #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [31:0]      instructionD,
  input  logic [WIDTH-1:0] pcplus4D,
  input  logic             flushE,
  input  logic             ForwardAD,
  input  logic             ForwardBD,
  input  logic [WIDTH-1:0] ALUOutM,
  input  logic             RegWriteW,
  input  logic [4:0]       WriteRegW,
  input  logic [WIDTH-1:0] ResultW,
  output logic             PCsrcD,
  output logic [WIDTH-1:0] pcBranchD,
  output logic [4:0]       RsD,
  output logic [4:0]       RtD,
  output logic             BranchD,
  output logic             RegWriteE,
  output logic             MemtoRegE,
  output logic             MemWriteE,
  output logic             ALUSrcE,
  output logic             RegDstE,
  output logic [2:0]       ALUControlE,
  output logic [WIDTH-1:0] RD1E,
  output logic [WIDTH-1:0] RD2E,
  output logic [4:0]       RsE,
  output logic [4:0]       RtE,
  output logic [4:0]       RdE,
  output logic [WIDTH-1:0] SignImmE
);

  logic [WIDTH-1:0] rf [NREGS];
  logic [WIDTH-1:0] rd1, rd2, signimm, cmp_a, cmp_b;
  logic [5:0]       opcode, funct;
  logic [4:0]       rdd;
  logic             regwrite, memtoreg, memwrite, alusrc, regdst;
  logic [2:0]       alucontrol;
  logic             wr_active;

  assign opcode = instructionD[31:26];
  assign funct  = instructionD[5:0];
  assign RsD    = instructionD[25:21];
  assign RtD    = instructionD[20:16];
  assign rdd    = instructionD[15:11];

  assign signimm = {{(WIDTH-16){instructionD[15]}}, instructionD[15:0]};

  // Register file; write port ignores register 0.
  assign wr_active = RegWriteW && (WriteRegW != 5'd0);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (wr_active) begin
      rf[WriteRegW] <= ResultW;
    end
  end

  // Reads: R0 is hard zero; a same-cycle writeback to the read index is bypassed.
  always_comb begin
    if (RsD == 5'd0)                        rd1 = '0;
    else if (wr_active && WriteRegW == RsD) rd1 = ResultW;
    else                                    rd1 = rf[RsD];
    if (RtD == 5'd0)                        rd2 = '0;
    else if (wr_active && WriteRegW == RtD) rd2 = ResultW;
    else                                    rd2 = rf[RtD];
  end

  // Main decoder; anything unlisted is an all-zero NOP.
  always_comb begin
    regwrite   = 1'b0;
    memtoreg   = 1'b0;
    memwrite   = 1'b0;
    alusrc     = 1'b0;
    regdst     = 1'b0;
    BranchD    = 1'b0;
    alucontrol = 3'b000;
    case (opcode)
      6'b000000: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default: begin
            // Unknown funct must not write the register file.
            alucontrol = 3'b010;
            regwrite   = 1'b0;
          end
        endcase
      end
      6'b100011: begin regwrite = 1'b1; alusrc = 1'b1; memtoreg = 1'b1; alucontrol = 3'b010; end
      6'b101011: begin alusrc = 1'b1; memwrite = 1'b1; alucontrol = 3'b010; end
      6'b000100: begin BranchD = 1'b1; alucontrol = 3'b110; end
      6'b001000: begin regwrite = 1'b1; alusrc = 1'b1; alucontrol = 3'b010; end
      default: ;
    endcase
  end

  // Branch resolution in ID. ALUOutM forwarding overrides the writeback bypass.
  assign cmp_a = ForwardAD ? ALUOutM : rd1;
  assign cmp_b = ForwardBD ? ALUOutM : rd2;

`ifdef JUMP_EN
  logic jumpd;
  assign jumpd = (opcode == 6'b000010);
  assign PCsrcD    = (BranchD && (cmp_a == cmp_b)) || jumpd;
  assign pcBranchD = jumpd ? {pcplus4D[31:28], instructionD[25:0], 2'b00}
                           : pcplus4D + {signimm[WIDTH-3:0], 2'b00};
`else
  assign PCsrcD    = BranchD && (cmp_a == cmp_b);
  assign pcBranchD = pcplus4D + {signimm[WIDTH-3:0], 2'b00};
`endif

  // ID/EX pipeline register; reset beats flush, flush loads an all-zero bubble.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset || flushE) begin
      RegWriteE   <= 1'b0;
      MemtoRegE   <= 1'b0;
      MemWriteE   <= 1'b0;
      ALUSrcE     <= 1'b0;
      RegDstE     <= 1'b0;
      ALUControlE <= 3'b000;
      RD1E        <= '0;
      RD2E        <= '0;
      RsE         <= 5'd0;
      RtE         <= 5'd0;
      RdE         <= 5'd0;
      SignImmE    <= '0;
    end else begin
      RegWriteE   <= regwrite;
      MemtoRegE   <= memtoreg;
      MemWriteE   <= memwrite;
      ALUSrcE     <= alusrc;
      RegDstE     <= regdst;
      ALUControlE <= alucontrol;
      RD1E        <= rd1;
      RD2E        <= rd2;
      RsE         <= RsD;
      RtE         <= RtD;
      RdE         <= rdd;
      SignImmE    <= signimm;
    end
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipeline stage directly downstream of the fetch stage in the 5-stage MIPS core.
- Consumes instructionD and pcplus4D from IF/ID and decodes the instruction.
- Holds the 32x32 register file, resolves beq in ID, and returns PCsrc/pcBranch to fetch.
- Captures control and operands in the ID/EX pipeline register for execute.

Parameters:
- WIDTH, 32, datapath and register width
- NREGS, 32, register file depth (index width 5)

Ports:
- CLK  input  1  pipeline clock; all state on rising edge
- reset  input  1  asynchronous, active-high; clears register file and ID/EX
- instructionD  input  32  instruction from IF/ID
- pcplus4D  input  32  PC+4 from IF/ID
- flushE  input  1  from hazard unit; load bubble into ID/EX next edge
- ForwardAD  input  1  branch operand A select: 1 = ALUOutM
- ForwardBD  input  1  branch operand B select: 1 = ALUOutM
- ALUOutM  input  32  memory-stage ALU result for branch forwarding
- RegWriteW  input  1  writeback enable
- WriteRegW  input  5  writeback register index
- ResultW  input  32  writeback data
- PCsrcD  output  1  branch taken; drives fetch PCsrc (also flushes IF/ID)
- pcBranchD  output  32  branch/jump target to fetch
- RsD  output  5  instructionD[25:21], to hazard unit
- RtD  output  5  instructionD[20:16], to hazard unit
- BranchD  output  1  decoded beq, to hazard unit
- RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE  output  1 each  registered control
- ALUControlE  output  3  registered ALU op
- RD1E, RD2E  output  32  registered operands
- RsE, RtE, RdE  output  5 each  registered register indices
- SignImmE  output  32  registered sign-extended immediate

Behaviour:
- Reset (async, active-high): all ID/EX outputs 0, all 32 registers 0. PCsrcD/pcBranchD are combinational, so reset forces nothing on them.
- Register file: 2 combinational read ports (rs, rt), 1 write port on CLK rising edge when RegWriteW=1 and WriteRegW!=0.
- Register 0 always reads 0. Writes to register 0 are ignored.
- Write-through bypass: if RegWriteW=1, WriteRegW!=0, and WriteRegW equals a read index, that port returns ResultW in the same cycle.
- Decode (opcode [31:26]); all other opcodes decode to an all-zero NOP:
  - R-type 000000: RegWrite=1, RegDst=1.
  - lw 100011: RegWrite=1, ALUSrc=1, MemtoReg=1.
  - sw 101011: ALUSrc=1, MemWrite=1.
  - beq 000100: Branch=1, ALUControl=110.
  - addi 001000: RegWrite=1, ALUSrc=1.
- ALUControl is 010 for lw/sw/addi.
- R-type funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111. Unknown funct → 010 with RegWrite=0.
- SignImm = {16{instr[15]}, instr[15:0]}.
- Branch target: pcBranchD = pcplus4D + (SignImm<<2), modulo 2^32, wrap silently.
- Branch compare: A = ForwardAD ? ALUOutM : RD1; B = ForwardBD ? ALUOutM : RD2. PCsrcD = BranchD & (A==B), combinational, zero added latency.
- ID/EX update on CLK rising edge, 1-cycle latency:
  - reset has priority over flushE.
  - flushE=1 loads all control bits 0 and all data fields 0.
  - Otherwise captures the decoded values.
- No stall input on ID/EX. Decode stall is applied at IF/ID. flushE during a stall is the required bubble insertion.
- Simultaneous writeback to rs and a branch on rs: bypass supplies ResultW to the compare unless ForwardAD=1, in which case ALUOutM wins.

Optional Feature:
- Macro JUMP_EN.
- When defined: opcode 000010 (j) decodes as JumpD=1 with all other control 0.
  - PCsrcD = (BranchD & eq) | JumpD.
  - When JumpD=1, pcBranchD = {pcplus4D[31:28], instr[25:0], 2'b00}.
- When undefined: opcode 000010 is a NOP and no jump logic is synthesized.

Test Plan:
- reset=1 mid-run with ID/EX holding lw control → all E outputs 0 immediately (asynchronous), before the next CLK edge.
- Write R5=0x0000_00AA via W port, then instructionD=add $3,$5,$0 (0x00A01820) → next edge RD1E=0xAA, RdE=3, RegWriteE=1, ALUControlE=010.
- Same-cycle write R7=0x1234 while decoding sw with rt=7 → RD2E=0x1234 (bypass). Write to R0=0xFFFF → reading R0 gives 0.
- beq $1,$2,+4 with R1=R2=9, pcplus4D=0x40 → PCsrcD=1, pcBranchD=0x50. With R2=8 → PCsrcD=0.
- beq with ForwardAD=1, ALUOutM=R2 value, R1 different → PCsrcD=1. flushE=1 on the same edge → all ID/EX control 0.
- JUMP_EN: instr 0x08000010, pcplus4D=0x1000_0004 → PCsrcD=1, pcBranchD=0x1000_0040. Without the macro → PCsrcD=0, RegWriteE=0.
